xtest_ch_arb: RTL and testbench
===============================

Name: xtest_ch_arb

Overview:
- Round-robin channel arbiter sitting directly upstream of the xtest datapath; its registered one-hot grant drives the xtest a_ch[3:0] input.
- Converts independent per-channel request lines into a clean, never-unknown channel-select stream.
- Each grant is held for a bounded number of cycles, followed by a programmable idle gap.
- Every output is a flop with a defined reset value, so downstream no-X properties hold from the first cycle after reset.

Parameters:
- N_CH, 4, number of channels; sets width of req and a_ch.
- HOLD, 3, maximum cycles a grant stays asserted (>=1).
- GAP, 1, cycles a_ch is forced to zero between grants (>=0).
- CNT_W, 8, width of the saturating grant counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; deassertion aborts any active grant.
- req  input  N_CH  per-channel request, level-sensitive.
- a_ch  output  N_CH  registered one-hot grant, or all-zero; feeds xtest.
- grant_vld  output  1  high exactly when a_ch is non-zero.
- grant_done  output  1  one-cycle pulse on the cycle after a grant ends normally.
- abort  output  1  one-cycle pulse on the cycle after a grant is cut by en=0.
- grant_cnt  output  CNT_W  count of completed grants; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a clock edge) forces the following; rst overrides everything, including mid-grant:
  - state=IDLE; a_ch=0; grant_vld=0; grant_done=0; abort=0; grant_cnt=0.
  - last pointer = N_CH-1, so channel 0 has first priority.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and req!=0, select the first set req bit searching upward from last+1, modulo N_CH.
  - On that edge: a_ch <= onehot(sel), last <= sel, hold counter <= HOLD-1, state <= GRANT.
  - Latency: req seen at edge k gives a_ch valid after edge k, i.e. 1 cycle.
  - Otherwise stay in IDLE with a_ch=0.
- GRANT (a_ch held constant):
  - Abort path, if en=0: a_ch <= 0, abort pulses, grant_cnt unchanged, state <= IDLE, with no gap.
  - End path, if en=1 and either (req[last]=0) or (hold counter = 0): a_ch <= 0, grant_done pulses, grant_cnt += 1 (saturating).
    - Then state <= GAP with gap counter = GAP-1 if GAP>0; else state <= IDLE.
  - Otherwise decrement the hold counter.
  - Priority: en=0 wins over the end conditions when they coincide.
- GAP:
  - a_ch=0.
  - Go to IDLE when the gap counter reaches 0; otherwise decrement.
  - en=0 in GAP goes to IDLE immediately, with no abort pulse.
- Back-to-back grants: with GAP=0, an ended grant spends exactly one IDLE cycle with a_ch=0 before the next grant.
- Arbitration is a pure function of registered last and the current req. Requests raised or dropped during GRANT/GAP are not latched.
- Invariants:
  - a_ch is always zero or one-hot.
  - grant_vld == (a_ch != 0).
  - grant_done and abort are never high together.
  - Every output is never X/Z after the first reset edge.
- Wrap-around: after channel N_CH-1 is granted, search resumes at channel 0.
- Counter saturation: at all-ones, further completions leave grant_cnt unchanged.

Test Plan:
- Reset then a single request: rst=1 for 2 cycles, then en=1, req=4'b0100 -> a_ch=4'b0100 one cycle later, held 3 cycles, then 0; grant_done pulses; grant_cnt=1.
- Round-robin fairness: req=4'b1111 held, HOLD=3, GAP=1 -> a_ch sequence 0001, 0010, 0100, 1000, 0001; each grant lasts 3 cycles with 1 gap cycle plus 1 IDLE cycle between grants.
- Early release: req[1] dropped one cycle into a grant of 4'b0010 -> a_ch=0 next edge; grant_done pulses; the next grant goes to channel 2 if it is requesting.
- Abort: en deasserted during the second cycle of a grant -> a_ch=0 next edge; abort=1 for one cycle; grant_cnt unchanged; with en=1 again, re-arbitration starts from last+1.
- Mid-grant reset: rst asserted during a GRANT on channel 3 -> all outputs 0 next edge; the next grant with req=4'b1001 goes to channel 0.
- Saturation: with CNT_W=2, 5 completed grants -> grant_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/xtest_ch_arb.sv
// Round-robin channel arbiter feeding the xtest a_ch select input.
// Grants are held for at most HOLD cycles and separated by GAP idle cycles.
module xtest_ch_arb #(
    parameter int N_CH  = 4,
    parameter int HOLD  = 3,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_CH-1:0]  req,
    output logic [N_CH-1:0]  a_ch,
    output logic             grant_vld,
    output logic             grant_done,
    output logic             abort,
    output logic [CNT_W-1:0] grant_cnt
);

    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int GAP_W  = (GAP > 1)  ? $clog2(GAP)  : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_last;
    logic [HOLD_W-1:0]  r_hold;
    logic [GAP_W-1:0]   r_gap;
    logic [N_CH-1:0]    r_a_ch;
    logic               r_vld;
    logic               r_done;
    logic               r_abort;
    logic [CNT_W-1:0]   r_cnt;

    logic [IDX_W-1:0]   w_sel;
    logic               w_found;
    logic [N_CH-1:0]    w_onehot;
    logic               w_req_any;
    logic               w_req_last;
    logic               w_cnt_max;
    int                 w_idx;

    // Search upward from last+1 so the most recently served channel is checked last.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 1; i <= N_CH; i++) begin
            w_idx = (int'(r_last) + i) % N_CH;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_sel] = 1'b1;
    end

    assign w_req_any  = |req;
    assign w_req_last = req[r_last];
    assign w_cnt_max  = &r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= IDX_W'(N_CH - 1);
            r_hold  <= '0;
            r_gap   <= '0;
            r_a_ch  <= '0;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en && w_req_any) begin
                        r_a_ch  <= w_onehot;
                        r_vld   <= 1'b1;
                        r_last  <= w_sel;
                        r_hold  <= HOLD_W'(HOLD - 1);
                        r_state <= S_GRANT;
                    end else begin
                        r_a_ch <= '0;
                        r_vld  <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (!en) begin
                        r_a_ch  <= '0;
                        r_vld   <= 1'b0;
                        r_abort <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (!w_req_last || (r_hold == '0)) begin
                        r_a_ch <= '0;
                        r_vld  <= 1'b0;
                        r_done <= 1'b1;
                        if (!w_cnt_max) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (GAP > 0) begin
                            r_gap   <= GAP_W'(GAP - 1);
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                S_GAP: begin
                    r_a_ch <= '0;
                    r_vld  <= 1'b0;
                    if (!en || (r_gap == '0)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                default: begin
                    r_a_ch  <= '0;
                    r_vld   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_ch       = r_a_ch;
    assign grant_vld  = r_vld;
    assign grant_done = r_done;
    assign abort      = r_abort;
    assign grant_cnt  = r_cnt;

endmodule

// File: tb/tb_xtest_ch_arb.sv
// Directed bench for xtest_ch_arb: expected outputs are queued as each step is
// driven and popped after the following clock edge.
module tb_xtest_ch_arb;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;

    logic [3:0] a_ch;
    logic       grant_vld;
    logic       grant_done;
    logic       abort;
    logic [7:0] grant_cnt;

    logic [3:0] s_a_ch;
    logic       s_grant_vld;
    logic       s_grant_done;
    logic       s_abort;
    logic [1:0] s_grant_cnt;

    typedef struct packed {
        logic [3:0] a;
        logic       done;
        logic       ab;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    xtest_ch_arb #(.N_CH(4), .HOLD(3), .GAP(1), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .a_ch       (a_ch),
        .grant_vld  (grant_vld),
        .grant_done (grant_done),
        .abort      (abort),
        .grant_cnt  (grant_cnt)
    );

    // Narrow-counter copy on the same stimulus, used for saturation.
    xtest_ch_arb #(.N_CH(4), .HOLD(3), .GAP(1), .CNT_W(2)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .a_ch       (s_a_ch),
        .grant_vld  (s_grant_vld),
        .grant_done (s_grant_done),
        .abort      (s_abort),
        .grant_cnt  (s_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] q,
                        input logic [3:0] ea, input logic ed, input logic eab,
                        input logic [7:0] ec);
        exp_t x;
        logic [7:0] ec2;
        @(negedge clk);
        rst = r;
        en  = e;
        req = q;
        x.a    = ea;
        x.done = ed;
        x.ab   = eab;
        x.cnt  = ec;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed=0 entries expected=1");
        end else begin
            x = sb.pop_front();
            ec2 = (x.cnt > 8'd3) ? 8'd3 : x.cnt;
            check("a_ch",       {4'h0, a_ch},        {4'h0, x.a});
            check("grant_vld",  {7'h0, grant_vld},   {7'h0, (x.a != 4'h0)});
            check("grant_done", {7'h0, grant_done},  {7'h0, x.done});
            check("abort",      {7'h0, abort},       {7'h0, x.ab});
            check("grant_cnt",  grant_cnt,           x.cnt);
            check("sat_a_ch",   {4'h0, s_a_ch},      {4'h0, x.a});
            check("sat_cnt",    {6'h0, s_grant_cnt}, ec2);
        end
    endtask

    // One full grant with req held: 3 cycles granted, done, then gap->idle.
    task automatic grant_seq(input logic [3:0] q, input int ch, input logic [7:0] cnt0);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        step(1'b0, 1'b1, q, oh,   1'b0, 1'b0, cnt0);
        step(1'b0, 1'b1, q, oh,   1'b0, 1'b0, cnt0);
        step(1'b0, 1'b1, q, oh,   1'b0, 1'b0, cnt0);
        step(1'b0, 1'b1, q, 4'h0, 1'b1, 1'b0, cnt0 + 8'd1);
        step(1'b0, 1'b1, q, 4'h0, 1'b0, 1'b0, cnt0 + 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 4'h0;

        // reset
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);

        // single request on channel 2
        step(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 4'b0100, 4'h0,    1'b1, 1'b0, 8'd1);
        step(1'b0, 1'b1, 4'h0,    4'h0,    1'b0, 1'b0, 8'd1);
        step(1'b0, 1'b1, 4'h0,    4'h0,    1'b0, 1'b0, 8'd1);

        // round robin with all requesting, wraps back to channel 0; narrow counter saturates
        step(1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);
        grant_seq(4'b1111, 0, 8'd0);
        grant_seq(4'b1111, 1, 8'd1);
        grant_seq(4'b1111, 2, 8'd2);
        grant_seq(4'b1111, 3, 8'd3);
        grant_seq(4'b1111, 0, 8'd4);

        // early release of channel 1, next grant goes to channel 2
        step(1'b0, 1'b1, 4'b0110, 4'b0010, 1'b0, 1'b0, 8'd5);
        step(1'b0, 1'b1, 4'b0100, 4'h0,    1'b1, 1'b0, 8'd6);
        step(1'b0, 1'b1, 4'b0100, 4'h0,    1'b0, 1'b0, 8'd6);
        step(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'd6);

        // abort in second grant cycle, re-arbitration resumes at channel 3
        step(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 8'd6);
        step(1'b0, 1'b0, 4'b0100, 4'h0,    1'b0, 1'b1, 8'd6);
        step(1'b0, 1'b0, 4'b0100, 4'h0,    1'b0, 1'b0, 8'd6);
        step(1'b0, 1'b1, 4'b1111, 4'b1000, 1'b0, 1'b0, 8'd6);

        // reset in the middle of a channel 3 grant
        step(1'b0, 1'b1, 4'b1111, 4'b1000, 1'b0, 1'b0, 8'd6);
        step(1'b1, 1'b1, 4'b1111, 4'h0,    1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 4'b1001, 4'h0,    1'b1, 1'b0, 8'd1);

        // en low in the gap skips straight to idle without abort
        step(1'b0, 1'b0, 4'b1001, 4'h0,    1'b0, 1'b0, 8'd1);
        step(1'b0, 1'b1, 4'b1001, 4'b1000, 1'b0, 1'b0, 8'd1);

        // en low and release together: abort wins
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'd1);
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
